// File: rtl/rvfi_seq_check.sv
// RVFI retirement checker: per-channel field compare against a spec model, reorder
// window drain with PC-continuity check, and a sticky first-error latch.
module rvfi_seq_check #(
  parameter int XLEN      = 32,
  parameter int NRET      = 2,
  parameter int ORDER_W   = 8,
  parameter int WINDOW    = 4,
  parameter bit ASSERT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET*5-1:0]       rvfi_rd,
  input  logic [NRET*XLEN-1:0]    rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0]    rvfi_post_pc,
  input  logic [NRET*XLEN-1:0]    rvfi_post_rd,
  input  logic [NRET-1:0]         rvfi_post_trap,
  input  logic [NRET-1:0]         spec_valid,
  input  logic [NRET*5-1:0]       spec_rd,
  input  logic [NRET*XLEN-1:0]    spec_post_rd,
  input  logic [NRET*XLEN-1:0]    spec_post_pc,
  input  logic [NRET-1:0]         spec_post_trap,
  output logic                    err,
  output logic [2:0]              err_code,
  output logic [1:0]              err_chan,
  output logic [ORDER_W-1:0]      err_order,
  output logic [ORDER_W-1:0]      next_order,
  output logic [31:0]             checked_count
);

  localparam int SW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  function automatic logic [SW-1:0] slot_of(input logic [ORDER_W-1:0] o);
    logic [ORDER_W-1:0] m;
    m = o & ORDER_W'(WINDOW - 1);
    return SW'(m);
  endfunction

  logic [WINDOW-1:0]  r_slot_vld;
  logic [XLEN-1:0]    r_slot_pre  [WINDOW];
  logic [XLEN-1:0]    r_slot_post [WINDOW];
  logic [ORDER_W-1:0] r_slot_ord  [WINDOW];
  logic [ORDER_W-1:0] r_next_order;
  logic [XLEN-1:0]    r_last_post_pc;
  logic               r_have_prev;
  logic               r_err;
  logic [2:0]         r_err_code;
  logic [1:0]         r_err_chan;
  logic [ORDER_W-1:0] r_err_order;
  logic [31:0]        r_checked;

  logic [ORDER_W-1:0] w_ord  [NRET];
  logic [ORDER_W-1:0] w_dist [NRET];
  logic [NRET-1:0]    w_cap, w_c1, w_c2, w_c3, w_c4, w_c6, w_wr;
  logic               w_cap_err;
  logic [2:0]         w_cap_code;
  logic [1:0]         w_cap_chan;
  logic [ORDER_W-1:0] w_cap_order;

  always_comb begin
    w_cap = '0; w_c1 = '0; w_c2 = '0; w_c3 = '0; w_c4 = '0; w_c6 = '0; w_wr = '0;
    w_cap_err = 1'b0; w_cap_code = '0; w_cap_chan = '0; w_cap_order = '0;
    for (int k = 0; k < NRET; k++) begin
      w_ord[k]  = rvfi_order[k*ORDER_W +: ORDER_W];
      w_dist[k] = w_ord[k] - r_next_order;
      w_cap[k]  = enable & rvfi_valid[k];
    end
    for (int k = 0; k < NRET; k++) begin
      w_c1[k] = w_cap[k] && spec_valid[k] && !spec_post_trap[k] &&
                ((rvfi_rd[k*5 +: 5] != spec_rd[k*5 +: 5]) ||
                 (rvfi_post_rd[k*XLEN +: XLEN] != spec_post_rd[k*XLEN +: XLEN]) ||
                 (rvfi_post_pc[k*XLEN +: XLEN] != spec_post_pc[k*XLEN +: XLEN]));
      w_c2[k] = w_cap[k] && spec_valid[k] && (spec_post_trap[k] != rvfi_post_trap[k]);
      w_c3[k] = w_cap[k] && (w_dist[k] >= ORDER_W'(WINDOW));
      for (int j = 0; j < NRET; j++) begin
        if (j != k && w_cap[k] && w_cap[j] && w_ord[j] == w_ord[k]) w_c6[k] = 1'b1;
      end
      w_c4[k] = w_cap[k] && !w_c3[k] && !w_c6[k] && r_slot_vld[slot_of(w_ord[k])];
      w_wr[k] = w_cap[k] && !w_c3[k] && !w_c6[k] && !w_c4[k];
    end
    // Walk from the highest channel down so the lowest erroring channel wins.
    for (int k = NRET - 1; k >= 0; k--) begin
      if (w_c1[k] || w_c2[k] || w_c3[k] || w_c4[k] || w_c6[k]) begin
        w_cap_err   = 1'b1;
        w_cap_chan  = 2'(k);
        w_cap_order = w_ord[k];
        if (w_c1[k])      w_cap_code = 3'd1;
        else if (w_c2[k]) w_cap_code = 3'd2;
        else if (w_c3[k]) w_cap_code = 3'd3;
        else if (w_c4[k]) w_cap_code = 3'd4;
        else              w_cap_code = 3'd6;
      end
    end
  end

  logic [WINDOW-1:0]  w_drain_mask;
  logic [ORDER_W-1:0] w_ndrain;
  logic [XLEN-1:0]    w_prev_pc;
  logic               w_prev_ok;
  logic               w_cont;
  logic               w_d5;
  logic [ORDER_W-1:0] w_d5_order;
  logic [SW-1:0]      w_didx;

  // Drain sees only slot state from the start of the cycle: no same-cycle bypass.
  always_comb begin
    w_drain_mask = '0;
    w_ndrain     = '0;
    w_prev_pc    = r_last_post_pc;
    w_prev_ok    = r_have_prev;
    w_cont       = enable;
    w_d5         = 1'b0;
    w_d5_order   = '0;
    w_didx       = '0;
    for (int i = 0; i < NRET; i++) begin
      w_didx = slot_of(r_next_order + ORDER_W'(i));
      if (w_cont && r_slot_vld[w_didx]) begin
        w_drain_mask[w_didx] = 1'b1;
        if (w_prev_ok && (r_slot_pre[w_didx] != w_prev_pc) && !w_d5) begin
          w_d5       = 1'b1;
          w_d5_order = r_slot_ord[w_didx];
        end
        w_prev_pc = r_slot_post[w_didx];
        w_prev_ok = 1'b1;
        w_ndrain  = w_ndrain + 1'b1;
      end else begin
        w_cont = 1'b0;
      end
    end
  end

  logic [2:0]  w_pop;
  logic [32:0] w_cnt_sum;
  logic        w_err_next;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NRET; k++) w_pop = w_pop + 3'(rvfi_valid[k] & spec_valid[k]);
    w_cnt_sum  = {1'b0, r_checked} + 33'(w_pop);
    w_err_next = w_cap_err | w_d5;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot_vld     <= '0;
      for (int w = 0; w < WINDOW; w++) begin
        r_slot_pre[w]  <= '0;
        r_slot_post[w] <= '0;
        r_slot_ord[w]  <= '0;
      end
      r_next_order   <= '0;
      r_last_post_pc <= '0;
      r_have_prev    <= 1'b0;
      r_err          <= 1'b0;
      r_err_code     <= '0;
      r_err_chan     <= '0;
      r_err_order    <= '0;
      r_checked      <= '0;
    end else if (enable) begin
      for (int w = 0; w < WINDOW; w++) begin
        if (w_drain_mask[w]) r_slot_vld[w] <= 1'b0;
      end
      for (int k = 0; k < NRET; k++) begin
        if (w_wr[k]) begin
          r_slot_vld[slot_of(w_ord[k])]  <= 1'b1;
          r_slot_pre[slot_of(w_ord[k])]  <= rvfi_pre_pc[k*XLEN +: XLEN];
          r_slot_post[slot_of(w_ord[k])] <= rvfi_post_pc[k*XLEN +: XLEN];
          r_slot_ord[slot_of(w_ord[k])]  <= w_ord[k];
        end
      end
      r_next_order   <= r_next_order + w_ndrain;
      r_last_post_pc <= w_prev_pc;
      r_have_prev    <= w_prev_ok;
      r_checked      <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
      if (!r_err && w_err_next) begin
        r_err <= 1'b1;
        if (w_cap_err) begin
          r_err_code  <= w_cap_code;
          r_err_chan  <= w_cap_chan;
          r_err_order <= w_cap_order;
        end else begin
          r_err_code  <= 3'd5;
          r_err_chan  <= 2'd0;
          r_err_order <= w_d5_order;
        end
      end
    end
  end

  assign err           = r_err;
  assign err_code      = r_err_code;
  assign err_chan      = r_err_chan;
  assign err_order     = r_err_order;
  assign next_order    = r_next_order;
  assign checked_count = r_checked;

  generate
    if (ASSERT_EN) begin : g_assert
      a_no_err: assert property (@(posedge clk) disable iff (!resetn) !w_err_next);
    end
  endgenerate

endmodule

// File: doc/rvfi_seq_check.md
Name: rvfi_seq_check

Overview:
Parametrised multi-channel RVFI retirement checker.
- Per channel: compares DUT retirement fields against spec-model results supplied on input ports.
- Across channels and cycles: reorders retirements by order number in a small window and checks PC continuity (post_pc of order n == pre_pc of order n+1).
- Reports the first error as sticky registered status for the formal harness and simulation benches.

Parameters:
XLEN, 32, register/PC width (32 or 64)
NRET, 2, retirement channels (1..4)
ORDER_W, 8, rvfi_order width; order arithmetic mod 2^ORDER_W
WINDOW, 4, reorder-window depth (power of 2, >= NRET, <= 16)
ASSERT_EN, 1, 1: also emit assert(!err_next) each cycle

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
enable  in  1  0: no checks, no state updates except reset
rvfi_valid  in  NRET  per-channel retire valid
rvfi_order  in  NRET*ORDER_W  instruction order number
rvfi_rd  in  NRET*5  destination register
rvfi_pre_pc  in  NRET*XLEN  PC before instruction
rvfi_post_pc  in  NRET*XLEN  PC after instruction
rvfi_post_rd  in  NRET*XLEN  rd writeback value
rvfi_post_trap  in  NRET  trap flag
spec_valid  in  NRET  spec model recognises the instruction
spec_rd / spec_post_rd / spec_post_pc / spec_post_trap  in  NRET*5 / NRET*XLEN / NRET*XLEN / NRET  spec results
err  out  1  sticky error flag
err_code  out  3  first error code
err_chan  out  2  channel of first error
err_order  out  ORDER_W  order of first error
next_order  out  ORDER_W  next order expected to drain
checked_count  out  32  fields-checked count, saturating

Behaviour:
- Reset (resetn=0, async): err=0, err_code=0, err_chan=0, err_order=0, next_order=0, checked_count=0, all slot valid bits 0, have_prev=0.
- Error codes:
  - 1 field mismatch: spec_valid, !spec_post_trap, and rd/post_rd/post_pc differs.
  - 2 trap mismatch: spec_valid and spec_post_trap != rvfi_post_trap.
  - 3 out of window: (order - next_order) mod 2^ORDER_W >= WINDOW.
  - 4 duplicate: target slot already valid.
  - 5 PC discontinuity.
  - 6 two valid channels carry the same order in one cycle.
- Capture cycle C, with enable=1 and rvfi_valid[k]=1: codes 1/2/3/6 are evaluated combinationally. Otherwise slot[order mod WINDOW] is written {pre_pc, post_pc, order} and its valid bit set at the end of C.
  - Code 4 is also raised at capture. The slot is not overwritten.
  - A code-3 or code-6 channel is not written.
- Drain cycle C+1: from head slot next_order mod WINDOW, drain up to NRET consecutive valid slots in order.
  - For each drained slot: if have_prev and pre_pc != last_post_pc, raise code 5 with that slot's order.
  - Then last_post_pc = post_pc, have_prev=1, clear slot, next_order += 1 (wraps mod 2^ORDER_W).
  - Drain stops at the first invalid slot.
  - Slots written in cycle C are not drainable until C+1 (no same-cycle bypass).
- Error timing: codes 1/2/3/4/6 appear on err at C+1; code 5 appears at C+2.
- First-error latch: when err=0 and any error is detected in a cycle, register err=1 and code/chan/order.
  - Priority: capture errors over drain errors; lowest channel first; then lowest code.
  - For drain errors, err_chan=0.
  - After err=1, err_code/chan/order freeze until reset; checking and draining continue.
- checked_count: += popcount(rvfi_valid & spec_valid) when enable=1; saturates at 32'hFFFFFFFF.
- enable=0: slots, next_order, counters and latch all hold.
- Full window: all WINDOW slots valid while the head slot is missing is legal. Arrivals beyond the window raise code 3.
- Reset mid-operation discards buffered retirements. After reset, next_order returns to 0.
- With ASSERT_EN=1, assert is combinational on the same conditions (no ordering delay).

Test Plan:
- In-order, NRET=2, WINDOW=4: cycle 0 orders 0,1 (pc 0→4, 4→8); cycle 1 orders 2,3 (8→C, C→10); all spec match. Response: err=0, next_order=4 after cycle 2, checked_count=4.
- Out-of-order: orders 1 then 0 in consecutive cycles with continuous PCs. Response: both drain the cycle after order 0 arrives, next_order=2, err=0.
- PC break: order 0 post_pc=0x4, order 1 pre_pc=0x8. Response: err=1, err_code=5, err_order=1 at capture+2.
- Window and duplicate checks:
  - With next_order=0, order 4 arrives: err_code=3.
  - In a separate run, order 2 arrives twice before drain: err_code=4, err_order=2.
- Field/priority: ch1 spec_post_rd=5 vs rvfi_post_rd=6 in the same cycle as ch0 trap mismatch. Response: err_code=2, err_chan=0; a later mismatch leaves the latch unchanged.
- Wrap and reset:
  - ORDER_W=8, run orders 250..261 continuous: next_order wraps 255→0, err=0.
  - Drop resetn mid-run with 2 slots valid: outputs zero immediately; order 0 is then accepted cleanly.
